// File: rtl/array_arb_pkg.sv
// Shared types and helpers for the two-port array arbiter.
package array_arb_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  // Fill pattern written during INIT: entry i holds 2*i+1.
  function automatic logic [15:0] init_value(input logic [7:0] idx);
    return {7'd0, idx, 1'b1};
  endfunction

endpackage

// File: rtl/array_arb_grant.sv
// Two-way grant logic. Round-robin on ties when ARRAY_ARB_RR_EN is defined,
// otherwise requester 0 always wins ties.
module array_arb_grant (
`ifdef ARRAY_ARB_RR_EN
  input  logic       last_grant_i,
`endif
  input  logic       valid0_i,
  input  logic       valid1_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (valid0_i && valid1_i) begin
`ifdef ARRAY_ARB_RR_EN
      // The requester that did not win last time takes the tie.
      grant_o = last_grant_i ? 2'b01 : 2'b10;
`else
      grant_o = 2'b01;
`endif
    end else if (valid0_i) begin
      grant_o = 2'b01;
    end else if (valid1_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/array_port_arbiter.sv
// Two-port arbiter/sequencer owning a small word array: fills it after reset,
// then serves one single-word access per cycle. Optional: ARRAY_ARB_RR_EN.
module array_port_arbiter
  import array_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_wdata,
  output logic              resp0_valid,
  output logic [WIDTH-1:0]  resp0_rdata,
  output logic              resp0_err,
  output logic              resp1_valid,
  output logic [WIDTH-1:0]  resp1_rdata,
  output logic              resp1_err,
  output logic              init_done
);

  localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   fill_idx_q;
  logic               init_done_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic               resp0_valid_q, resp1_valid_q;
  logic [WIDTH-1:0]   resp0_rdata_q, resp1_rdata_q;
  logic               resp0_err_q, resp1_err_q;

  logic [1:0]         grant;
  logic               run;
  logic               acc;
  logic               acc_we;
  logic [ADDR_W-1:0]  acc_addr;
  logic [WIDTH-1:0]   acc_wdata;
  logic               acc_in_range;
  logic [IDX_W-1:0]   acc_idx;
  logic [WIDTH-1:0]   acc_old;

`ifdef ARRAY_ARB_RR_EN
  logic               last_grant_q;
`endif

  array_arb_grant u_grant (
`ifdef ARRAY_ARB_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .grant_o      (grant)
  );

  assign run        = (state_q == ST_RUN);
  assign req0_ready = run && grant[0];
  assign req1_ready = run && grant[1];

  // Reset gates acceptance so an in-flight request leaves no trace.
  assign acc        = (req0_ready || req1_ready) && !reset;

  always_comb begin
    acc_we    = req0_we;
    acc_addr  = req0_addr;
    acc_wdata = req0_wdata;
    if (grant[1]) begin
      acc_we    = req1_we;
      acc_addr  = req1_addr;
      acc_wdata = req1_wdata;
    end
  end

  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_A);
  assign acc_idx      = acc_addr[IDX_W-1:0];
  assign acc_old      = acc_in_range ? mem_q[acc_idx] : '0;

  // Storage is deliberately not reset; INIT rewrites every entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_INIT) begin
        mem_q[fill_idx_q] <= WIDTH'(init_value(8'(fill_idx_q)));
      end else if (acc && acc_we && acc_in_range) begin
        mem_q[acc_idx] <= acc_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      fill_idx_q    <= '0;
      init_done_q   <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
      resp0_err_q   <= 1'b0;
      resp1_err_q   <= 1'b0;
`ifdef ARRAY_ARB_RR_EN
      last_grant_q  <= 1'b1;
`endif
    end else begin
      resp0_valid_q <= acc && grant[0];
      resp1_valid_q <= acc && grant[1];
      if (acc && grant[0]) begin
        resp0_rdata_q <= acc_old;
        resp0_err_q   <= !acc_in_range;
      end
      if (acc && grant[1]) begin
        resp1_rdata_q <= acc_old;
        resp1_err_q   <= !acc_in_range;
      end
`ifdef ARRAY_ARB_RR_EN
      if (acc) begin
        last_grant_q <= grant[1];
      end
`endif
      case (state_q)
        ST_INIT: begin
          if (fill_idx_q == LAST_IDX) begin
            fill_idx_q  <= '0;
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            fill_idx_q <= fill_idx_q + 1'b1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign resp0_valid = resp0_valid_q;
  assign resp0_rdata = resp0_rdata_q;
  assign resp0_err   = resp0_err_q;
  assign resp1_valid = resp1_valid_q;
  assign resp1_rdata = resp1_rdata_q;
  assign resp1_err   = resp1_err_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_array_port_arbiter.sv
// Directed self-checking bench for array_port_arbiter (default 4 x 32-bit).
module tb_array_port_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic        req0_we, req1_we;
  logic [7:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp0_rdata, resp1_rdata;
  logic        resp0_err, resp1_err;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  array_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_we     (req0_we),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_we     (req1_we),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .resp0_valid (resp0_valid),
    .resp0_rdata (resp0_rdata),
    .resp0_err   (resp0_err),
    .resp1_valid (resp1_valid),
    .resp1_rdata (resp1_rdata),
    .resp1_err   (resp1_err),
    .init_done   (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reset for one edge, then walk the 4 fill cycles with both requesters waiting.
  task automatic reset_and_fill(input string tag);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'd0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'd0;
    check_eq({tag, " rst resp0_valid"}, 64'(resp0_valid), 64'd0);
    check_eq({tag, " rst resp1_valid"}, 64'(resp1_valid), 64'd0);
    check_eq({tag, " rst resp0_rdata"}, 64'(resp0_rdata), 64'd0);
    check_eq({tag, " rst resp1_rdata"}, 64'(resp1_rdata), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("%s init_done c%0d", tag, c), 64'(init_done), 64'd0);
      check_eq($sformatf("%s ready0 c%0d", tag, c), 64'(req0_ready), 64'd0);
      check_eq($sformatf("%s ready1 c%0d", tag, c), 64'(req1_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, " init_done high"}, 64'(init_done), 64'd1);
    check_eq({tag, " no stray resp0"}, 64'(resp0_valid), 64'd0);
    check_eq({tag, " no stray resp1"}, 64'(resp1_valid), 64'd0);
  endtask

  // Single access on one port; called #1 after a rising edge (or mid-cycle).
  task automatic access(input int port, input logic we, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input string tag);
    if (port == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
    @(negedge clk);
    check_eq({tag, " ready"}, 64'((port == 0) ? req0_ready : req1_ready), 64'd1);
    @(posedge clk);
    #1;
    if (port == 0) begin
      req0_valid = 1'b0;
      check_eq({tag, " resp_valid"}, 64'(resp0_valid), 64'd1);
      check_eq({tag, " rdata"}, 64'(resp0_rdata), 64'(exp_rdata));
      check_eq({tag, " err"}, 64'(resp0_err), 64'(exp_err));
    end else begin
      req1_valid = 1'b0;
      check_eq({tag, " resp_valid"}, 64'(resp1_valid), 64'd1);
      check_eq({tag, " rdata"}, 64'(resp1_rdata), 64'(exp_rdata));
      check_eq({tag, " err"}, 64'(resp1_err), 64'(exp_err));
    end
  endtask

  logic exp0;

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    @(negedge clk);

    reset_and_fill("boot");

    // Fill pattern read back through req0, back-to-back.
    access(0, 1'b0, 8'd0, 32'd0, 32'd1, 1'b0, "rd0");
    access(0, 1'b0, 8'd1, 32'd0, 32'd3, 1'b0, "rd1");
    access(0, 1'b0, 8'd2, 32'd0, 32'd5, 1'b0, "rd2");
    access(0, 1'b0, 8'd3, 32'd0, 32'd7, 1'b0, "rd3");
    @(posedge clk);
    #1;
    check_eq("pulse resp0_valid low", 64'(resp0_valid), 64'd0);
    check_eq("hold resp0_rdata", 64'(resp0_rdata), 64'd7);

    // Out-of-range read and write: error, zero data, array untouched.
    access(0, 1'b0, 8'd9, 32'd0, 32'd0, 1'b1, "oor rd");
    access(0, 1'b1, 8'd4, 32'hFFFF, 32'd0, 1'b1, "oor wr");
    access(0, 1'b0, 8'd0, 32'd0, 32'd1, 1'b0, "rerd0");
    access(0, 1'b0, 8'd1, 32'd0, 32'd3, 1'b0, "rerd1");
    access(0, 1'b0, 8'd2, 32'd0, 32'd5, 1'b0, "rerd2");
    access(0, 1'b0, 8'd3, 32'd0, 32'd7, 1'b0, "rerd3");

    // Write returns old data; a read the next cycle sees the new data.
    access(1, 1'b1, 8'd2, 32'hDEAD, 32'd5, 1'b0, "wr2");
    access(1, 1'b0, 8'd2, 32'd0, 32'hDEAD, 1'b0, "rd2 new");

    // Continuous contention for six cycles; last grant went to requester 1.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'd0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'd1;
    for (int i = 0; i < 6; i++) begin
`ifdef ARRAY_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      @(negedge clk);
      check_eq($sformatf("tie ready0 %0d", i), 64'(req0_ready), 64'(exp0));
      check_eq($sformatf("tie ready1 %0d", i), 64'(req1_ready), 64'(!exp0));
      @(posedge clk);
      #1;
      check_eq($sformatf("tie resp0 %0d", i), 64'(resp0_valid), 64'(exp0));
      check_eq($sformatf("tie resp1 %0d", i), 64'(resp1_valid), 64'(!exp0));
      if (exp0) check_eq($sformatf("tie rdata0 %0d", i), 64'(resp0_rdata), 64'd1);
      else      check_eq($sformatf("tie rdata1 %0d", i), 64'(resp1_rdata), 64'd3);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Reset lands while a write to addr 1 is being presented.
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'd1; req0_wdata = 32'h55;
    @(negedge clk);
    reset_and_fill("midrst");

    // First tie after reset: requester 0 wins, then requester 1 sees its write.
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'd3; req0_wdata = 32'hA;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'd3;
    @(negedge clk);
    check_eq("first tie ready0", 64'(req0_ready), 64'd1);
    check_eq("first tie ready1", 64'(req1_ready), 64'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    check_eq("first tie resp0_valid", 64'(resp0_valid), 64'd1);
    check_eq("first tie resp0_rdata", 64'(resp0_rdata), 64'd7);
    check_eq("first tie resp1_valid", 64'(resp1_valid), 64'd0);
    @(negedge clk);
    check_eq("second ready1", 64'(req1_ready), 64'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    check_eq("second resp1_valid", 64'(resp1_valid), 64'd1);
    check_eq("second resp1_rdata", 64'(resp1_rdata), 64'hA);

    // Fill after the mid-stream reset rewrote the earlier writes.
    access(0, 1'b0, 8'd1, 32'd0, 32'd3, 1'b0, "post rst rd1");
    access(0, 1'b0, 8'd2, 32'd0, 32'd5, 1'b0, "post rst rd2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_port_arbiter.md
# array_port_arbiter

Two-port arbiter and sequencer for a small shared word array (default 4 x 32-bit). After reset it runs an initialization fill, then grants single-word read/write requests from two requesters, one access per cycle, with registered responses. It sits between the test/compute FSMs and the shared array storage, which the block owns internally.

## Interface
- `DEPTH`, 4: number of array entries, 2..256.
- `WIDTH`, 32: data width in bits.
- `ADDR_W`, 8: request address width; addresses >= `DEPTH` are errors.
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when valid && ready.
- `req0_we`, `req1_we`  in  1  1 = write, 0 = read.
- `req0_addr`, `req1_addr`  in  `ADDR_W`  word index.
- `req0_wdata`, `req1_wdata`  in  `WIDTH`  write data.
- `resp0_valid`, `resp1_valid`  out  1  one-cycle response pulse.
- `resp0_rdata`, `resp1_rdata`  out  `WIDTH`  entry contents at acceptance (old value for writes).
- `resp0_err`, `resp1_err`  out  1  address out of range; qualified by respN_valid.
- `init_done`  out  1  high once the fill completes, low during INIT.

## Operation
- FSM states: INIT, RUN.
- INIT: entered on reset. Counter `fill_idx` runs 0..DEPTH-1, writing entry i = 2*i+1 (WIDTH-bit, zero-extended), one entry per cycle. After writing DEPTH-1 → RUN, `init_done` <= 1. Both readies are 0 in INIT; requests wait.
- RUN: at most one grant per cycle.
  - Only one valid: that requester is granted.
  - Both valid: arbitration per Configuration.
  - `reqN_ready` = grant to N; combinational from valids and priority state, 0 when not valid.
- Accepted access:
  - Read: rdata = arr[addr].
  - Write: rdata = old arr[addr]; arr[addr] <= wdata at the same edge.
  - addr >= DEPTH: no array update, rdata = 0, err = 1.
- Priority state (`last_grant`) updates only on an accepted request.
- Reset values: all ready/resp outputs 0, rdata 0, `init_done` 0, `fill_idx` 0, `last_grant` 1 (requester 0 wins the first tie), state INIT. Array contents are not reset; INIT rewrites them.
- Reset asserted mid-RUN or mid-INIT: the in-flight response is dropped, the FSM restarts INIT at index 0, and the fill repeats fully.

## Timing
- INIT lasts exactly DEPTH cycles after reset deasserts; first grant possible on cycle DEPTH+1 (`init_done` high that cycle).
- Response latency: `respN_valid` is high exactly the cycle after acceptance, for one cycle; rdata/err are valid that cycle and held until the next response on that port.
- Back-to-back: one requester can be accepted every cycle (no bubbles).
- A read accepted the cycle after a write to the same address returns the new data.
- Requester must hold valid/we/addr/wdata stable until ready; the block does not latch unaccepted requests.

## Configuration
- `ARRAY_ARB_RR_EN` defined: round-robin on ties; the requester not in `last_grant` wins, so alternation is strict under continuous contention.
- Not defined: fixed priority, requester 0 always wins ties (requester 1 may starve); `last_grant` logic is removed.

## Structure
- Package `array_arb_pkg`: FSM state enum (`ST_INIT`, `ST_RUN`) and the init-value function (2*i+1).
- Sub-module `array_arb_grant`: 2-way grant logic (valids, `last_grant`, macro) → one-hot grant. Storage, FSM and response registers stay in the top.

## Test plan
- Reset, then read addr 0..3 via req0 → rdata 1,3,5,7, err 0, each 1 cycle after accept; no ready during the first 4 cycles.
- req1 write addr 2 = 0xDEAD then read addr 2 next cycle → write resp rdata 5, read resp rdata 0xDEAD.
- Both valid for 6 cycles, RR enabled → grants 0,1,0,1,0,1; RR disabled → six grants to 0, req1 ready stays 0.
- req0 read addr 9 → resp0_err 1, rdata 0, array unchanged (re-read 0..3 gives 1,3,5,7).
- Write addr 1 = 0x55, assert reset mid-stream for 1 cycle → no response for the in-flight request, `init_done` low 4 cycles, addr 1 reads back 3.
- Simultaneous req0 write addr 3 = 0xA and req1 read addr 3, RR enabled, first tie after reset → req0 first (resp rdata 7), req1 next cycle reads 0xA.
